// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: decode-stage issue controller with immediate-gen hookup, 2-entry skid buffer, flush and stall counter
module id_issue_ctrl #(
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [PC_W-1:0]  if_pc,
  input  logic [31:0]      if_inst,
  input  logic             flush,
  output logic [31:0]      gen_inst,
  output logic [2:0]       gen_type,
  input  logic [63:0]      gen_imm_data,
  input  logic [5:0]       gen_imm_shift,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [PC_W-1:0]  id_pc,
  output logic [31:0]      id_inst,
  output logic [63:0]      id_imm,
  output logic [5:0]       id_shamt,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int P_W = PC_W + 32 + 64 + 6;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nx;
  logic [P_W-1:0] main_q, skid_q;
  logic in_x, out_x, load_main, load_skid, pop_skid;
  assign gen_inst = if_inst;
  assign if_ready = (state != FULL) & rst_n;
  assign id_valid = (state != EMPTY);
  assign in_x     = if_valid & if_ready;
  assign out_x    = id_valid & id_ready;
  assign {id_pc, id_inst, id_imm, id_shamt} = main_q;
  // immediate format select from the opcode
  always_comb begin
    gen_type = 3'b000;
    case (if_inst[6:0])
      7'b0100011:                                     gen_type = 3'b011;
      7'b0110111, 7'b0010111:                         gen_type = 3'b100;
      7'b1101111:                                     gen_type = 3'b101;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0011011: gen_type = 3'b110;
      7'b1100011:                                     gen_type = 3'b111;
      default:                                        gen_type = 3'b000;
    endcase
  end
  // buffer occupancy transitions; flush empties the buffer and drops any incoming beat
  always_comb begin
    state_nx  = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    case (state)
      EMPTY: begin
        load_main = in_x;
        state_nx  = in_x ? ONE : EMPTY;
      end
      ONE: begin
        load_main = in_x & out_x;
        load_skid = in_x & !out_x;
        state_nx  = (in_x & !out_x) ? FULL : (!in_x & out_x) ? EMPTY : ONE;
      end
      FULL: begin
        pop_skid = out_x;
        state_nx = out_x ? ONE : FULL;
      end
      default: state_nx = EMPTY;
    endcase
    if (flush) begin
      state_nx  = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      pop_skid  = 1'b0;
    end
  end
  // state, payload registers and saturating stall counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      if (load_main) main_q <= {if_pc, if_inst, gen_imm_data, gen_imm_shift};
      else if (pop_skid) main_q <= skid_q;
      if (load_skid) skid_q <= {if_pc, if_inst, gen_imm_data, gen_imm_shift};
      if (id_valid & !id_ready & ~&stall_cnt) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_id_issue_ctrl.sv
// tb_id_issue_ctrl: directed self-checking bench for id_issue_ctrl
module tb_id_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, if_valid, if_ready, flush, id_valid, id_ready;
  logic [63:0] if_pc, id_pc, gen_imm_data, id_imm;
  logic [31:0] if_inst, gen_inst, id_inst;
  logic [2:0]  gen_type;
  logic [5:0]  gen_imm_shift, id_shamt;
  logic [3:0]  stall_cnt;
  int tests = 0;
  int fails = 0;
  id_issue_ctrl #(.PC_W(64), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .flush(flush), .gen_inst(gen_inst),
    .gen_type(gen_type), .gen_imm_data(gen_imm_data), .gen_imm_shift(gen_imm_shift),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
    .id_imm(id_imm), .id_shamt(id_shamt), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] imm, input logic [5:0] sh);
    if_valid = 1'b1;
    if_pc = pc;
    if_inst = inst;
    gen_imm_data = imm;
    gen_imm_shift = sh;
  endtask
  initial begin
    rst_n = 1'b0; if_valid = 1'b0; id_ready = 1'b0; flush = 1'b0;
    if_pc = '0; if_inst = '0; gen_imm_data = '0; gen_imm_shift = '0;
    #1;
    chk("rst_if_ready", if_ready, 0);
    tick(); tick();
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_stall", stall_cnt, 0);
    rst_n = 1'b1; #1;
    chk("rel_if_ready", if_ready, 1);
    id_ready = 1'b1;
    beat(64'h1000, 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 6'h3F); #1;
    chk("addi_type", gen_type, 3'b110);
    chk("addi_gen_inst", gen_inst, 32'hFFF00093);
    tick();
    chk("addi_valid", id_valid, 1);
    chk("addi_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_shamt", id_shamt, 6'h3F);
    chk("addi_pc", id_pc, 64'h1000);
    beat(64'h1004, 32'h123450B7, 64'h0000_0000_1234_5000, 6'h00); #1;
    chk("lui_type", gen_type, 3'b100);
    tick();
    chk("lui_imm", id_imm, 64'h0000_0000_1234_5000);
    chk("lui_pc", id_pc, 64'h1004);
    beat(64'h1008, 32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 6'h3C); #1;
    chk("beq_type", gen_type, 3'b111);
    tick();
    chk("beq_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_valid", id_valid, 1);
    beat(64'h100C, 32'h003100B3, 64'h0, 6'h00); #1;
    chk("add_type", gen_type, 3'b000);
    tick();
    chk("add_imm", id_imm, 64'h0);
    chk("add_inst", id_inst, 32'h003100B3);
    if_valid = 1'b0;
    tick();
    chk("drain_valid", id_valid, 0);
    chk("stream_stall", stall_cnt, 0);
    id_ready = 1'b0;
    beat(64'h2000, 32'h00100093, 64'd1, 6'd1);
    tick();
    chk("bp_a_pc", id_pc, 64'h2000);
    chk("bp_ready1", if_ready, 1);
    beat(64'h2004, 32'h00200093, 64'd2, 6'd2);
    tick();
    chk("bp_ready_drop", if_ready, 0);
    chk("bp_stall1", stall_cnt, 1);
    chk("bp_hold_pc", id_pc, 64'h2000);
    beat(64'h2008, 32'h00300093, 64'd3, 6'd3);
    tick();
    chk("bp_stall2", stall_cnt, 2);
    chk("bp_hold_imm", id_imm, 64'd1);
    tick();
    chk("bp_stall3", stall_cnt, 3);
    chk("bp_still_full", if_ready, 0);
    id_ready = 1'b1;
    tick();
    chk("bp_b_pc", id_pc, 64'h2004);
    chk("bp_b_imm", id_imm, 64'd2);
    chk("bp_ready_back", if_ready, 1);
    chk("bp_stall_hold", stall_cnt, 3);
    tick();
    chk("bp_c_pc", id_pc, 64'h2008);
    chk("bp_c_shamt", id_shamt, 6'd3);
    if_valid = 1'b0;
    tick();
    chk("bp_empty", id_valid, 0);
    id_ready = 1'b0;
    beat(64'h3000, 32'h00400093, 64'd4, 6'd4);
    tick();
    beat(64'h3004, 32'h00500093, 64'd5, 6'd5);
    tick();
    chk("fl_full", if_ready, 0);
    beat(64'h3008, 32'h00600093, 64'd6, 6'd6);
    flush = 1'b1; id_ready = 1'b1; #1;
    chk("fl_xfer_valid", id_valid, 1);
    chk("fl_xfer_pc", id_pc, 64'h3000);
    tick();
    chk("fl_empty", id_valid, 0);
    chk("fl_if_ready", if_ready, 1);
    chk("fl_stall_kept", stall_cnt, 4);
    flush = 1'b0; if_valid = 1'b0;
    tick();
    chk("fl_no_ghost", id_valid, 0);
    beat(64'h4000, 32'h00700093, 64'd7, 6'd7);
    tick();
    chk("fl1_pc", id_pc, 64'h4000);
    beat(64'h4004, 32'h00800093, 64'd8, 6'd8);
    flush = 1'b1;
    tick();
    chk("fl1_empty", id_valid, 0);
    flush = 1'b0; if_valid = 1'b0;
    tick();
    chk("fl1_no_ghost", id_valid, 0);
    id_ready = 1'b0;
    beat(64'h5000, 32'h00900093, 64'd9, 6'd9);
    tick();
    beat(64'h5004, 32'h00A00093, 64'd10, 6'd10);
    tick();
    if_valid = 1'b0;
    tick();
    chk("rs_pre_stall", stall_cnt, 6);
    rst_n = 1'b0; #1;
    chk("rs_if_ready_low", if_ready, 0);
    tick();
    chk("rs_valid", id_valid, 0);
    chk("rs_pc", id_pc, 0);
    chk("rs_inst", id_inst, 0);
    chk("rs_imm", id_imm, 0);
    chk("rs_shamt", id_shamt, 0);
    chk("rs_stall", stall_cnt, 0);
    tick();
    chk("rs_if_ready_hold", if_ready, 0);
    rst_n = 1'b1; #1;
    chk("rs_if_ready_rel", if_ready, 1);
    beat(64'h6000, 32'h00B00093, 64'd11, 6'd11);
    tick();
    if_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("sat_15", stall_cnt, 15);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold", stall_cnt, 15);
    chk("sat_pc", id_pc, 64'h6000);
    id_ready = 1'b1;
    tick();
    chk("sat_drain", id_valid, 0);
    chk("sat_final", stall_cnt, 15);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
